// File: rtl/ipv4_pkg.sv
// Shared IPv4 receive constants, FSM encoding and the ones' complement helper.
package ipv4_pkg;

    localparam int IPV4_HEAD_LEN = 20;
    localparam int IPV4_VER      = 4;
    localparam int IPV4_IHL      = 5;

    localparam int OFF_VER_IHL = 0;
    localparam int OFF_TLEN    = 2;
    localparam int OFF_FLAGS   = 6;
    localparam int OFF_PROTO   = 9;
    localparam int OFF_SRC     = 12;
    localparam int OFF_DST     = 16;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_HEAD    = 2'd1;
    localparam logic [1:0] ST_PAYLOAD = 2'd2;
    localparam logic [1:0] ST_DROP    = 2'd3;

    // Carry out of the previous add is folded back in on the next add.
    function automatic logic [16:0] csum_add(input logic [16:0] acc,
                                             input logic [15:0] w);
        return {1'b0, acc[15:0]} + {1'b0, w} + {16'd0, acc[16]};
    endfunction

endpackage

// File: rtl/ipv4_rx_csum.sv
// Running IPv4 header checksum; ok_o reflects the sum including the current beat.
module ipv4_rx_csum
    import ipv4_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              clear_i,
    input  logic              en_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              ok_o
);

    localparam int WORDS_N = DATA_W / 16;

    logic [16:0] acc_q;
    logic [16:0] acc_d;
    logic [16:0] sum;
    logic [16:0] fold1;
    logic [15:0] fold2;

    always_comb begin
        sum = clear_i ? 17'd0 : acc_q;
        for (int j = 0; j < WORDS_N; j++) begin
            sum = csum_add(sum, {data_i[16*j +: 8], data_i[16*j+8 +: 8]});
        end
        acc_d = en_i ? sum : acc_q;
        fold1 = {1'b0, sum[15:0]} + {16'd0, sum[16]};
        fold2 = fold1[15:0] + {15'd0, fold1[16]};
        ok_o  = (fold2 == 16'hFFFF);
    end

    always_ff @(posedge clk) begin
        if (nreset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/ipv4_rx.sv
// IPv4 receive stage: header parse/check, header strip, padding trim,
// per-frame status. All outputs registered.
module ipv4_rx
    import ipv4_pkg::*;
#(
    parameter  int DATA_W       = 16,
    localparam int DATA_BYTES_N = DATA_W / 8,
    localparam int LEN_W        = $clog2(DATA_W / 8) + 1
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              cancel_i,
    input  logic              valid_i,
    input  logic              start_i,
    input  logic              term_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic              crc_err_i,
    output logic              valid_o,
    output logic              start_o,
    output logic              term_o,
    output logic [DATA_W-1:0] data_o,
    output logic [LEN_W-1:0]  len_o,
    output logic [7:0]        proto_o,
    output logic [31:0]       src_o,
    output logic [31:0]       dst_o,
    output logic              done_o,
    output logic              err_o,
    output logic              drop_o
);

    localparam int HB     = IPV4_HEAD_LEN / DATA_BYTES_N;
    localparam int HDR_W  = 8 * IPV4_HEAD_LEN;
    localparam int HCNT_W = $clog2(HB);

    if (DATA_W != 16 && DATA_W != 32) begin : g_bad_width
        $error("ipv4_rx: DATA_W must be 16 or 32");
    end

    function automatic logic [31:0] swap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    logic [1:0]              state_q,  state_d;
    logic [HCNT_W-1:0]       hcnt_q,   hcnt_d;
    logic [15:0]             rem_q,    rem_d;
    logic                    first_q,  first_d;
    logic [HDR_W-DATA_W-1:0] hdr_q,    hdr_d;
    logic                    valid_q,  valid_d;
    logic                    start_q,  start_d;
    logic                    term_q,   term_d;
    logic [DATA_W-1:0]       data_q,   data_d;
    logic [LEN_W-1:0]        len_q,    len_d;
    logic [7:0]              proto_q,  proto_d;
    logic [31:0]             src_q,    src_d;
    logic [31:0]             dst_q,    dst_d;
    logic                    done_q,   done_d;
    logic                    err_q,    err_d;
    logic                    drop_q,   drop_d;

    logic [HDR_W-1:0]  hdr_sh;
    logic              hdr_beat;
    logic [HCNT_W-1:0] cnt_idx;
    logic              hdr_last;
    logic              csum_ok;
    logic              hdr_ok;
    logic [15:0]       tlen;
    logic [7:0]        ver_ihl;
    logic [7:0]        flg_hi;
    logic [7:0]        flg_lo;
    logic [15:0]       len_ext;
    logic [15:0]       emit;
    logic [15:0]       rem_nx;

    // Header bytes shift in from the top so byte k lands at hdr_sh[8k+:8].
    assign hdr_sh   = {data_i, hdr_q};
    assign hdr_beat = valid_i & (start_i | (state_q == ST_HEAD));
    assign cnt_idx  = start_i ? '0 : hcnt_q;
    assign hdr_last = (cnt_idx == HCNT_W'(HB - 1));

    assign ver_ihl = hdr_sh[8*OFF_VER_IHL +: 8];
    assign tlen    = {hdr_sh[8*OFF_TLEN +: 8], hdr_sh[8*(OFF_TLEN+1) +: 8]};
    assign flg_hi  = hdr_sh[8*OFF_FLAGS +: 8];
    assign flg_lo  = hdr_sh[8*(OFF_FLAGS+1) +: 8];

    assign hdr_ok = csum_ok
                  & (ver_ihl[7:4] == 4'(IPV4_VER))
                  & (ver_ihl[3:0] == 4'(IPV4_IHL))
                  & (tlen >= 16'(IPV4_HEAD_LEN))
                  & ~flg_hi[5]
                  & ({flg_hi[4:0], flg_lo} == 13'd0);

    assign len_ext = 16'(len_i);
    assign emit    = (rem_q < len_ext) ? rem_q : len_ext;
    assign rem_nx  = rem_q - emit;

    ipv4_rx_csum #(.DATA_W(DATA_W)) u_csum (
        .clk     (clk),
        .nreset  (nreset),
        .clear_i (start_i),
        .en_i    (hdr_beat & ~cancel_i),
        .data_i  (data_i),
        .ok_o    (csum_ok)
    );

    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        rem_d   = rem_q;
        first_d = first_q;
        hdr_d   = hdr_q;
        valid_d = 1'b0;
        start_d = 1'b0;
        term_d  = 1'b0;
        data_d  = data_q;
        len_d   = '0;
        proto_d = proto_q;
        src_d   = src_q;
        dst_d   = dst_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        drop_d  = 1'b0;

        if (cancel_i) begin
            done_d  = (state_q == ST_PAYLOAD);
            err_d   = (state_q == ST_PAYLOAD);
            state_d = ST_IDLE;
            hcnt_d  = '0;
        end else if (valid_i) begin
            // A fresh start aborts an open payload frame as a cancel.
            if (start_i && state_q == ST_PAYLOAD) begin
                done_d = 1'b1;
                err_d  = 1'b1;
            end
            if (hdr_beat) begin
                hdr_d = hdr_sh[HDR_W-1:DATA_W];
                if (!hdr_last) begin
                    hcnt_d  = term_i ? '0 : cnt_idx + HCNT_W'(1);
                    state_d = term_i ? ST_IDLE : ST_HEAD;
                    drop_d  = term_i;
                end else begin
                    hcnt_d = '0;
                    if (hdr_ok) begin
                        proto_d = hdr_sh[8*OFF_PROTO +: 8];
                        src_d   = swap32(hdr_sh[8*OFF_SRC +: 32]);
                        dst_d   = swap32(hdr_sh[8*OFF_DST +: 32]);
                        rem_d   = tlen - 16'(IPV4_HEAD_LEN);
                        first_d = 1'b1;
                        state_d = term_i ? ST_IDLE : ST_PAYLOAD;
                        done_d  = term_i;
                        err_d   = term_i
                                & (crc_err_i | (tlen != 16'(IPV4_HEAD_LEN)));
                    end else begin
                        drop_d  = 1'b1;
                        state_d = term_i ? ST_IDLE : ST_DROP;
                    end
                end
            end else if (state_q == ST_PAYLOAD) begin
                if (emit != 16'd0) begin
                    valid_d = 1'b1;
                    start_d = first_q;
                    term_d  = (rem_nx == 16'd0) | term_i;
                    data_d  = data_i;
                    len_d   = emit[LEN_W-1:0];
                    first_d = 1'b0;
                    rem_d   = rem_nx;
                end
                if (term_i) begin
                    done_d  = 1'b1;
                    err_d   = crc_err_i | (rem_nx != 16'd0);
                    state_d = ST_IDLE;
                end
            end else if (state_q == ST_DROP && term_i) begin
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (nreset) begin
            state_q <= ST_IDLE;
            hcnt_q  <= '0;
            rem_q   <= '0;
            first_q <= 1'b0;
            hdr_q   <= '0;
            valid_q <= 1'b0;
            start_q <= 1'b0;
            term_q  <= 1'b0;
            data_q  <= '0;
            len_q   <= '0;
            proto_q <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            rem_q   <= rem_d;
            first_q <= first_d;
            hdr_q   <= hdr_d;
            valid_q <= valid_d;
            start_q <= start_d;
            term_q  <= term_d;
            data_q  <= data_d;
            len_q   <= len_d;
            proto_q <= proto_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            done_q  <= done_d;
            err_q   <= err_d;
            drop_q  <= drop_d;
        end
    end

    assign valid_o = valid_q;
    assign start_o = start_q;
    assign term_o  = term_q;
    assign data_o  = data_q;
    assign len_o   = len_q;
    assign proto_o = proto_q;
    assign src_o   = src_q;
    assign dst_o   = dst_q;
    assign done_o  = done_q;
    assign err_o   = err_q;
    assign drop_o  = drop_q;

endmodule

// File: tb/tb_ipv4_rx.sv
// Scoreboard bench for ipv4_rx (16-bit datapath): directed frames then random traffic.
module tb_ipv4_rx;

    localparam int DATA_W = 16;
    localparam int LEN_W  = 2;

    logic              clk = 1'b0;
    logic              nreset = 1'b1;
    logic              cancel_i = 1'b0;
    logic              valid_i = 1'b0;
    logic              start_i = 1'b0;
    logic              term_i = 1'b0;
    logic [DATA_W-1:0] data_i = '0;
    logic [LEN_W-1:0]  len_i = '0;
    logic              crc_err_i = 1'b0;
    logic              valid_o, start_o, term_o;
    logic [DATA_W-1:0] data_o;
    logic [LEN_W-1:0]  len_o;
    logic [7:0]        proto_o;
    logic [31:0]       src_o, dst_o;
    logic              done_o, err_o, drop_o;

    ipv4_rx #(.DATA_W(DATA_W)) dut (
        .clk       (clk),
        .nreset    (nreset),
        .cancel_i  (cancel_i),
        .valid_i   (valid_i),
        .start_i   (start_i),
        .term_i    (term_i),
        .data_i    (data_i),
        .len_i     (len_i),
        .crc_err_i (crc_err_i),
        .valid_o   (valid_o),
        .start_o   (start_o),
        .term_o    (term_o),
        .data_o    (data_o),
        .len_o     (len_o),
        .proto_o   (proto_o),
        .src_o     (src_o),
        .dst_o     (dst_o),
        .done_o    (done_o),
        .err_o     (err_o),
        .drop_o    (drop_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] data;
        logic [1:0]  len;
        logic        st;
        logic        tm;
        logic [7:0]  proto;
        logic [31:0] src;
        logic [31:0] dst;
    } beat_t;

    typedef struct packed {
        logic drop;
        logic err;
    } ev_t;

    beat_t      exp_b[$];
    ev_t        exp_e[$];
    logic [7:0] fr[$];
    bit         gaps_en = 1'b0;
    int         checks = 0;
    int         failures = 0;
    beat_t      mb;
    ev_t        me;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: pop expected items whenever the DUT presents an output.
    always @(negedge clk) begin
        if (valid_o === 1'b1) begin
            if (exp_b.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_beat actual=data %h expected=none", data_o);
            end else begin
                mb = exp_b.pop_front();
                chk("len_o", 32'(len_o), 32'(mb.len));
                chk("data_o", mb.len == 2'd2 ? 32'(data_o) : 32'(data_o[7:0]),
                    32'(mb.data));
                chk("start_o", 32'(start_o), 32'(mb.st));
                chk("term_o", 32'(term_o), 32'(mb.tm));
                if (mb.st) begin
                    chk("proto_o", 32'(proto_o), 32'(mb.proto));
                    chk("src_o", src_o, mb.src);
                    chk("dst_o", dst_o, mb.dst);
                end
            end
        end
        if (done_o === 1'b1 || drop_o === 1'b1) begin
            if (exp_e.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_event actual=done %b drop %b expected=none",
                         done_o, drop_o);
            end else begin
                me = exp_e.pop_front();
                chk("event_kind", {30'd0, done_o, drop_o},
                    me.drop ? 32'd1 : 32'd2);
                if (!me.drop) chk("err_o", 32'(err_o), 32'(me.err));
            end
        end
    end

    task automatic mk_frame(input int tlen, input logic [7:0] b0,
                            input logic [7:0] b6, input logic [7:0] b7,
                            input logic [7:0] proto, input int flen,
                            input bit bad_csum);
        int s;
        logic [15:0] cs;
        fr.delete();
        fr.push_back(b0);
        fr.push_back(8'h00);
        fr.push_back(8'(tlen >> 8));
        fr.push_back(8'(tlen));
        fr.push_back(8'($urandom));
        fr.push_back(8'($urandom));
        fr.push_back(b6);
        fr.push_back(b7);
        fr.push_back(8'h40);
        fr.push_back(proto);
        fr.push_back(8'h00);
        fr.push_back(8'h00);
        for (int k = 0; k < 8; k++) fr.push_back(8'($urandom));
        s = 0;
        for (int k = 0; k < 10; k++) s += {fr[2*k], fr[2*k+1]};
        while ((s >> 16) != 0) s = (s & 'hFFFF) + (s >> 16);
        cs = ~16'(s);
        fr[10] = cs[15:8];
        fr[11] = cs[7:0];
        if (bad_csum) fr[10] = fr[10] ^ 8'h01;
        while (fr.size() < flen) fr.push_back(8'($urandom));
        while (fr.size() > flen) void'(fr.pop_back());
    endtask

    // Reference: what the frame in fr should produce when d beats are
    // delivered, ending with term (mode 0), cancel (1) or a new start (2).
    task automatic expect_frame(input int mode, input int d, input bit crc);
        int    flen, tlen, s, delivered, pe, lo, hi;
        bit    term, ok, first, have;
        beat_t pend, nb;
        flen = fr.size();
        term = (mode == 0);
        if (d < 10) begin
            if (term) exp_e.push_back(2'b10);
            return;
        end
        tlen = {fr[2], fr[3]};
        s = 0;
        for (int k = 0; k < 10; k++) s += {fr[2*k], fr[2*k+1]};
        while ((s >> 16) != 0) s = (s & 'hFFFF) + (s >> 16);
        ok = (fr[0][7:4] == 4'd4) && (fr[0][3:0] == 4'd5) && (s == 'hFFFF)
             && (tlen >= 20) && !fr[6][5] && ({fr[6][4:0], fr[7]} == 13'd0);
        if (!ok) begin
            exp_e.push_back(2'b10);
            return;
        end
        delivered = (2 * d < flen) ? 2 * d : flen;
        pe = (tlen < delivered) ? tlen : delivered;
        first = 1'b1;
        have = 1'b0;
        pend = '0;
        for (int i = 10; i < d; i++) begin
            lo = 2 * i;
            hi = (2 * i + 2 < pe) ? 2 * i + 2 : pe;
            if (hi > lo) begin
                if (have) exp_b.push_back(pend);
                nb.len   = 2'(hi - lo);
                nb.data  = {(hi - lo == 2) ? fr[lo+1] : 8'h00, fr[lo]};
                nb.st    = first;
                nb.tm    = 1'b0;
                nb.proto = fr[9];
                nb.src   = {fr[12], fr[13], fr[14], fr[15]};
                nb.dst   = {fr[16], fr[17], fr[18], fr[19]};
                pend     = nb;
                have     = 1'b1;
                first    = 1'b0;
            end
        end
        if (have) begin
            pend.tm = (pe == tlen) || term;
            exp_b.push_back(pend);
        end
        if (term) exp_e.push_back({1'b0, crc || (tlen > flen)});
        else exp_e.push_back(2'b01);
    endtask

    task automatic drive_frame(input int mode, input int d, input bit crc);
        int flen, nbeats;
        flen = fr.size();
        nbeats = (flen + 1) / 2;
        for (int i = 0; i < d; i++) begin
            if (gaps_en && $urandom_range(0, 3) == 0) begin
                valid_i = 1'b0;
                start_i = 1'b0;
                term_i  = 1'b0;
                @(posedge clk); #1;
            end
            valid_i   = 1'b1;
            start_i   = (i == 0);
            term_i    = (mode == 0) && (i == nbeats - 1);
            crc_err_i = term_i && crc;
            len_i     = (2 * i + 1 < flen) ? 2'd2 : 2'd1;
            data_i    = {(2 * i + 1 < flen) ? fr[2*i+1] : 8'($urandom), fr[2*i]};
            @(posedge clk); #1;
        end
        if (mode == 1) begin
            valid_i  = 1'($urandom);
            start_i  = 1'b0;
            term_i   = 1'b0;
            cancel_i = 1'b1;
            @(posedge clk); #1;
            cancel_i = 1'b0;
        end
        valid_i   = 1'b0;
        start_i   = 1'b0;
        term_i    = 1'b0;
        crc_err_i = 1'b0;
    endtask

    task automatic run_frame(input int mode, input int d, input bit crc);
        expect_frame(mode, d, crc);
        drive_frame(mode, d, crc);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_flags"},
            {25'd0, valid_o, start_o, term_o, done_o, err_o, drop_o, 1'b0}, 32'd0);
        chk({tag, "_data"}, {14'd0, len_o, data_o}, 32'd0);
        chk({tag, "_proto"}, 32'(proto_o), 32'd0);
        chk({tag, "_src"}, src_o, 32'd0);
        chk({tag, "_dst"}, dst_o, 32'd0);
    endtask

    initial begin
        int tlen, flen, mode, d, r;
        logic [7:0] b0, b6, b7;
        bit bad, crc;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        @(posedge clk); #1;
        nreset = 1'b0;
        @(posedge clk); #1;

        mk_frame(32, 8'h45, 8'h40, 8'h00, 8'h11, 32, 1'b0);
        run_frame(0, 16, 1'b0);
        mk_frame(32, 8'h45, 8'h40, 8'h00, 8'h11, 46, 1'b0);
        run_frame(0, 23, 1'b1);
        mk_frame(32, 8'h45, 8'h40, 8'h00, 8'h11, 32, 1'b1);
        run_frame(0, 16, 1'b0);
        mk_frame(64, 8'h45, 8'h40, 8'h00, 8'h06, 50, 1'b0);
        run_frame(0, 25, 1'b0);
        mk_frame(32, 8'h45, 8'h20, 8'h00, 8'h11, 32, 1'b0);
        run_frame(0, 16, 1'b0);
        mk_frame(20, 8'h45, 8'h40, 8'h00, 8'h01, 46, 1'b0);
        run_frame(0, 23, 1'b0);

        mk_frame(32, 8'h45, 8'h40, 8'h00, 8'h11, 32, 1'b0);
        run_frame(1, 12, 1'b0);
        mk_frame(32, 8'h45, 8'h40, 8'h00, 8'h11, 32, 1'b0);
        run_frame(0, 16, 1'b0);
        mk_frame(32, 8'h45, 8'h40, 8'h00, 8'h11, 32, 1'b0);
        run_frame(0, 16, 1'b0);

        mk_frame(32, 8'h45, 8'h40, 8'h00, 8'h11, 32, 1'b0);
        drive_frame(2, 4, 1'b0);
        nreset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_zero("midreset");
        @(posedge clk); #1;
        nreset = 1'b0;
        mk_frame(32, 8'h45, 8'h40, 8'h00, 8'h11, 32, 1'b0);
        run_frame(0, 16, 1'b0);
        repeat (3) @(posedge clk); #1;

        gaps_en = 1'b1;
        for (int n = 0; n < 40; n++) begin
            tlen = ($urandom_range(0, 4) == 0) ? 20 : 20 + $urandom_range(0, 60);
            b0 = 8'h45;
            b6 = 8'h40;
            b7 = 8'h00;
            bad = 1'b0;
            r = $urandom_range(0, 11);
            case (r)
                0: bad = 1'b1;
                1: b0 = 8'h65;
                2: b0 = 8'h46;
                3: b6 = 8'h60;
                4: b7 = 8'h03;
                5: tlen = $urandom_range(0, 19);
                default: ;
            endcase
            case ($urandom_range(0, 3))
                0: flen = tlen;
                1: flen = ((tlen > 46) ? tlen : 46) + $urandom_range(0, 2);
                2: flen = 20 + $urandom_range(0, (tlen > 20) ? tlen - 20 : 0);
                default: flen = 2 * $urandom_range(1, 9);
            endcase
            if (flen < 20 && flen != 2 * (flen / 2)) flen = flen - 1;
            if (flen < 2) flen = 2;
            mk_frame(tlen, b0, b6, b7, 8'($urandom), flen, bad);
            r = $urandom_range(0, 9);
            mode = (r < 7 || n == 39) ? 0 : (r < 8) ? 1 : 2;
            d = (mode == 0) ? (flen + 1) / 2 : $urandom_range(1, (flen + 1) / 2);
            crc = ($urandom_range(0, 3) == 0);
            run_frame(mode, d, crc);
        end

        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("beats_left", exp_b.size(), 32'd0);
        chk("events_left", exp_e.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
